// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
// Bit timing comes from an external strobe at 16x the bit rate.
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic                 tx_start_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);
  localparam logic       ParOdd   = (PARITY_ODD != 0);
  localparam logic       ParEn    = (PARITY_EN != 0);

  state_e               state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = baud_tick_i && (tick_q == 4'd15);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (state_q != StIdle && baud_tick_i) begin
      tick_d = tick_q + 4'd1;
    end

    // tx_d is the level for the next bit; it only moves on bit_end so the line never glitches.
    case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start_i) begin
          shift_d  = tx_data_i;
          parity_d = (^tx_data_i) ^ ParOdd;
          tick_d   = 4'd0;
          bit_d    = 3'd0;
          state_d  = StStart;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == LastData) begin
            bit_d = 3'd0;
            if (ParEn) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == LastStop) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      tick_q   <= 4'd0;
      bit_q    <= 3'd0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter variants share stimulus; per-variant monitors decode
// frames tick by tick and check them against queued expected frames.
module tb_uart_tx;

  localparam int NI = 4;
  // Variants: default, even parity, odd parity, two stop bits.
  localparam int unsigned P_EN  [NI] = '{0, 1, 1, 0};
  localparam int unsigned P_ODD [NI] = '{0, 0, 1, 0};
  localparam int unsigned N_STOP[NI] = '{1, 1, 1, 2};

  typedef logic [11:0] frame_t;
  typedef struct {
    logic [7:0] data;
    logic       par_even;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [NI-1:0] tx, busy, done;

  int     errors = 0;
  int     checks = 0;
  frame_t exp_q[NI][$];
  int     done_cnt[NI];
  int     done_cyc[NI];
  int     start_cyc[NI];
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int bcnt;
    bcnt      = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (bcnt == 3);
      bcnt      = (bcnt + 1) % 4;
    end
  end

  function automatic frame_t exp_frame(input int k, input logic [7:0] d, input logic pe);
    frame_t f;
    int     idx;
    f = '0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    idx = 9;
    if (P_EN[k] != 0) begin
      f[idx] = pe ^ (P_ODD[k] != 0);
      idx++;
    end
    for (int s = 0; s < int'(N_STOP[k]); s++) f[idx+s] = 1'b1;
    return f;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx #(
      .DATA_BITS (8),
      .PARITY_EN (P_EN[g]),
      .PARITY_ODD(P_ODD[g]),
      .STOP_BITS (N_STOP[g])
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .baud_tick_i(baud_tick),
      .tx_start_i (tx_start),
      .tx_data_i  (tx_data),
      .tx_o       (tx[g]),
      .tx_busy_o  (busy[g]),
      .tx_done_o  (done[g])
    );

    initial begin : mon
      bit     in_frame, ok, t, r;
      int     ticks, slots;
      frame_t got, exp;
      logic   tx_prev, busy_prev;
      slots       = 1 + 8 + int'(P_EN[g]) + int'(N_STOP[g]);
      in_frame    = 0;
      ok          = 1;
      ticks       = 0;
      got         = '0;
      tx_prev     = 1'b1;
      busy_prev   = 1'b0;
      done_cnt[g] = 0;
      done_cyc[g] = 0;
      start_cyc[g] = 0;
      forever begin
        @(posedge clk);
        t = baud_tick;
        r = rst;
        #2;
        if (done[g] === 1'b1) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
        end
        if (r) begin
          in_frame = 0;
        end else if (!in_frame) begin
          if (done[g] === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL spurious_done[%0d]: tx_done=1 with no frame in progress", g);
          end
          if (busy[g] === 1'b1 && busy_prev !== 1'b1) begin
            in_frame     = 1;
            ticks        = 0;
            got          = '0;
            ok           = (tx[g] === 1'b0);
            start_cyc[g] = cyc;
          end
        end else begin
          if (t) ticks++;
          if (t && ticks % 16 == 8 && ticks / 16 < 12) got[ticks/16] = tx[g];
          if (tx[g] !== tx_prev && !(t && ticks % 16 == 0)) ok = 0;
          if (done[g] === 1'b1) begin
            checks++;
            if (ticks != 16 * slots) begin
              errors++;
              $display("FAIL frame_len[%0d]: got %0d ticks, want %0d", g, ticks, 16 * slots);
            end
            checks++;
            if (exp_q[g].size() == 0) begin
              errors++;
              $display("FAIL unexpected_frame[%0d]: got bits %h, want no frame", g, got);
            end else begin
              exp = exp_q[g].pop_front();
              checks++;
              if (got !== exp) begin
                errors++;
                $display("FAIL frame_bits[%0d]: got %h, want %h", g, got, exp);
              end
            end
            checks++;
            if (!ok || busy[g] !== 1'b0) begin
              errors++;
              $display("FAIL protocol[%0d]: got ok=%0b busy=%b, want ok=1 busy=0", g, ok, busy[g]);
            end
            in_frame = 0;
          end else if (busy[g] !== 1'b1 || ticks > 16 * slots) begin
            checks++;
            errors++;
            $display("FAIL frame_abort[%0d]: got busy=%b at tick %0d, want busy=1 until done",
                     g, busy[g], ticks);
            if (exp_q[g].size() != 0) void'(exp_q[g].pop_front());
            in_frame = 0;
          end
        end
        busy_prev = busy[g];
        tx_prev   = tx[g];
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input bit push);
    if (push) for (int k = 0; k < NI; k++) exp_q[k].push_back(exp_frame(k, d, pe));
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
    end while (busy !== '0 && n < budget);
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%b after %0d cycles, want 0", busy, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    checks++;
    if (tx !== '1) begin
      errors++;
      $display("FAIL %s_tx: got %b, want all 1", tag, tx);
    end
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("FAIL %s_busy: got %b, want 0", tag, busy);
    end
    checks++;
    if (done !== '0) begin
      errors++;
      $display("FAIL %s_done: got %b, want 0", tag, done);
    end
  endtask

  initial begin
    vec_t tbl[8];
    int   base[NI];
    int   n;
    bit   all;

    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'hFF, 1'b0};
    tbl[2] = '{8'h00, 1'b0};
    tbl[3] = '{8'h01, 1'b1};
    tbl[4] = '{8'h80, 1'b1};
    tbl[5] = '{8'h5A, 1'b0};
    tbl[6] = '{8'h3C, 1'b0};
    tbl[7] = '{8'h7F, 1'b1};

    // Reset with a request pending: must be ignored.
    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    repeat (5) @(posedge clk);
    #2;
    check_reset_outs("reset");
    tx_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("post_reset");

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].data, tbl[i].par_even, 1);
      wait_idle(2000);
    end

    // Back-to-back: tx_start held, each variant re-accepts in its own done cycle.
    for (int k = 0; k < NI; k++) begin
      exp_q[k].push_back(exp_frame(k, 8'h00, 1'b0));
      exp_q[k].push_back(exp_frame(k, 8'hFF, 1'b0));
      base[k] = done_cnt[k];
    end
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
      all = 1;
      for (int k = 0; k < NI; k++) if (done_cnt[k] <= base[k]) all = 0;
    end while (!all && n < 2000);
    checks++;
    if (!all) begin
      errors++;
      $display("FAIL b2b_first_done: got none within %0d cycles, want a done per variant", n);
    end
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    #2;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (start_cyc[k] - done_cyc[k] != 1) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: got %0d cycles done->start, want 1", k,
                 start_cyc[k] - done_cyc[k]);
      end
    end
    wait_idle(2000);

    // Mid-frame request with different data must not disturb the frame.
    send(8'hA5, 1'b0, 1);
    repeat (120) @(posedge clk);
    #1;
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    wait_idle(2000);

    // Reset about 50 ticks into a frame abandons it without tx_done.
    send(8'h5A, 1'b0, 0);
    repeat (199) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) base[k] = done_cnt[k];
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset_outs("mid_reset");
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (done_cnt[k] != base[k] || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL abandon[%0d]: got done_cnt=%0d busy=%b, want %0d and 0", k,
                 done_cnt[k], busy[k], base[k]);
      end
    end
    @(posedge clk);
    #1;
    send(8'h5A, 1'b0, 1);
    wait_idle(2000);
    repeat (10) @(posedge clk);
    #3;

    for (int k = 0; k < NI; k++) begin
      checks++;
      if (exp_q[k].size() != 0 || done_cnt[k] != 12) begin
        errors++;
        $display("FAIL final_count[%0d]: got pending=%0d done=%0d, want 0 and 12", k,
                 exp_q[k].size(), done_cnt[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter: PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-003 Parameter: PARITY_ODD, default 0, 0 selects even parity and 1 selects odd parity (used only when PARITY_EN=1).
REQ-004 Parameter: STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-005 Port: clk  input  1  system clock; all logic is on the rising edge.
REQ-006 Port: rst  input  1  synchronous, active-high reset.
REQ-007 Port: baud_tick  input  1  one-clk strobe at 16x the bit rate.
REQ-008 Port: tx_start  input  1  send request, sampled every clk.
REQ-009 Port: tx_data  input  DATA_BITS  byte to send, sampled on the clk where the request is accepted.
REQ-010 Port: tx  output  1  serial line, registered; idle level is 1.
REQ-011 Port: tx_busy  output  1  high while a frame is in progress.
REQ-012 Port: tx_done  output  1  one-clk pulse marking frame completion.

Function
REQ-013 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP; any unused encoding SHALL go to IDLE with tx=1.
REQ-014 A request is accepted only in IDLE with tx_start=1; on that edge the block SHALL:
- latch tx_data into a shift register;
- clear the tick counter and the bit counter;
- enter START;
- drive tx=0 and tx_busy=1 from the next cycle.
REQ-015 tx_start SHALL be ignored while tx_busy=1, and tx_data changes after acceptance SHALL NOT affect the frame in progress.
REQ-016 Each bit SHALL be held for exactly 16 baud_ticks; the 4-bit tick counter increments on baud_tick only, and the bit period ends on the baud_tick where the counter equals 15.
REQ-017 Clk cycles without baud_tick SHALL hold all state, with no drift.
REQ-018 START SHALL drive 0 for one bit period, then enter DATA.
REQ-019 DATA SHALL send DATA_BITS bits LSB first, shifting once per bit period.
REQ-020 After the last data bit, DATA SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-021 PARITY SHALL drive the XOR of the latched data bits for even parity, or its complement for odd parity, for one bit period.
REQ-022 STOP SHALL drive 1 for STOP_BITS x 16 baud_ticks, then enter IDLE.
REQ-023 On the STOP-to-IDLE edge, tx_busy SHALL fall and tx_done SHALL rise for exactly one clk.
REQ-024 tx_start in the tx_done cycle SHALL be accepted, giving a back-to-back frame with no extra idle bit.
REQ-025 Frame length SHALL be (1 + DATA_BITS + PARITY_EN + STOP_BITS) x 16 baud_ticks.
REQ-026 tx SHALL be glitch-free: it changes only at bit boundaries or on reset.

Reset
REQ-027 While rst=1, the block SHALL hold state=IDLE, tx=1, tx_busy=0, tx_done=0, and zero in the tick counter, bit counter and shift register.
REQ-028 rst=1 during a frame SHALL abandon the frame: tx=1 on the next edge, with no tx_done.
REQ-029 tx_start asserted during reset SHALL be ignored.
REQ-030 After reset release, the first accepted request SHALL produce a complete, correct frame.

Verification
REQ-031 Defaults, tx_data=0xA5, baud_tick every 4 clk:
- tx sequence: 0,1,0,1,0,0,1,0,1,1, each held 16 ticks;
- tx_done pulses once, 160 ticks after acceptance;
- tx_busy is high throughout the frame.
REQ-032 PARITY_EN=1, PARITY_ODD=0, tx_data=0xA5 -> parity bit 0 in the 10th slot; PARITY_ODD=1 -> parity bit 1; frame = 176 ticks.
REQ-033 STOP_BITS=2, tx_data=0xFF -> stop level 1 held 32 ticks; tx_done at tick 176.
REQ-034 Back-to-back: tx_start held high, tx_data=0x00 then 0xFF -> the second start bit begins in the first bit period after the first stop; no idle gap; two tx_done pulses.
REQ-035 tx_start re-pulsed with 0x3C mid-frame -> ignored; the frame in progress is unchanged.
REQ-036 rst at tick 50 of a frame -> tx=1 next clk, tx_busy=0, no tx_done; a new 0x5A request then transmits correctly.
